// File: rtl/command_handler_pkg.sv
// VT52-subset decoder constants: ASCII control codes, ESC command letters, FSM encoding.
package command_handler_pkg;

   localparam int COLS = 64;
   localparam int ROWS = 16;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_TAB   = 8'h09;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_ESC   = 8'h1B;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_DEL   = 8'h7F;

   localparam logic [7:0] ESC_UP    = 8'h41;  // 'A'
   localparam logic [7:0] ESC_DOWN  = 8'h42;  // 'B'
   localparam logic [7:0] ESC_RIGHT = 8'h43;  // 'C'
   localparam logic [7:0] ESC_LEFT  = 8'h44;  // 'D'
   localparam logic [7:0] ESC_HOME  = 8'h48;  // 'H'
   localparam logic [7:0] ESC_EOS   = 8'h4A;  // 'J'
   localparam logic [7:0] ESC_EOL   = 8'h4B;  // 'K'
   localparam logic [7:0] ESC_ADDR  = 8'h59;  // 'Y'

   typedef enum logic [2:0] {
      S_INIT,
      S_FILL_START,
      S_FILL,
      S_IDLE,
      S_ESC,
      S_Y_ROW,
      S_Y_COL
   } state_t;

endpackage

// File: rtl/command_handler_fill_engine.sv
// Writes FILL_CHAR-independent addresses for logical cells from..to inclusive, one per cycle.
// First write is registered on the start cycle; busy drops with the last write.
module fill_engine #(
   parameter int COL_BITS = 6,
   parameter int ROW_BITS = 4
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         start,
   input  logic [ROW_BITS+COL_BITS-1:0] from,
   input  logic [ROW_BITS+COL_BITS-1:0] to,
   input  logic [ROW_BITS-1:0]          first_row,
   output logic                         busy,
   output logic [ROW_BITS+COL_BITS-1:0] waddr,
   output logic                         wen
);
   localparam int AW = ROW_BITS + COL_BITS;

   logic [AW-1:0] idx;
   logic [AW-1:0] last;

   // Logical row is offset by the scroll register; the row field wraps by design.
   always_ff @(posedge clk) begin
      if (clr) begin
         busy  <= 1'b0;
         wen   <= 1'b0;
         waddr <= '0;
         idx   <= '0;
         last  <= '0;
      end else if (start) begin
         wen   <= 1'b1;
         waddr <= {first_row + from[AW-1:COL_BITS], from[COL_BITS-1:0]};
         idx   <= from + 1'b1;
         last  <= to;
         busy  <= (from != to);
      end else if (busy) begin
         wen   <= 1'b1;
         waddr <= {first_row + idx[AW-1:COL_BITS], idx[COL_BITS-1:0]};
         idx   <= idx + 1'b1;
         busy  <= (idx != last);
      end else begin
         wen   <= 1'b0;
      end
   end

endmodule

// File: rtl/command_handler.sv
// VT52-subset byte interpreter: cursor tracking, char buffer writes and hardware scroll.
// Fills (clear, scroll, erase) stall the byte stream with ready=0 until the last cell is written.
module command_handler
   import command_handler_pkg::*;
#(
   parameter int          COL_BITS  = 6,
   parameter int          ROW_BITS  = 4,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic [7:0]                   data,
   input  logic                         valid,
   output logic                         ready,
   output logic [ROW_BITS+COL_BITS-1:0] buffer_waddr,
   output logic [7:0]                   buffer_din,
   output logic                         buffer_wen,
   output logic [ROW_BITS-1:0]          buffer_first_row,
   output logic                         buffer_first_row_wen,
   output logic [ROW_BITS-1:0]          cursor_row,
   output logic [COL_BITS-1:0]          cursor_col
);
   localparam int AW = ROW_BITS + COL_BITS;
   localparam logic [COL_BITS-1:0] COL_MAX  = '1;
   localparam logic [ROW_BITS-1:0] ROW_MAX  = '1;
   localparam logic [COL_BITS-1:0] TAB_MASK = 7;
   localparam logic [7:0]          ROW_LIM  = 8'((1 << ROW_BITS) - 1);
   localparam logic [7:0]          COL_LIM  = 8'((1 << COL_BITS) - 1);

   state_t            state;
   logic              accept;
   logic [7:0]        arg;
   logic [COL_BITS:0] tab_col;
   logic [ROW_BITS-1:0] y_row;
   logic [AW-1:0]     fill_lo, fill_hi, fill_from, fill_to, fill_waddr, chr_addr;
   logic              fill_start, fill_busy, fill_wen, chr_wen;
   logic [7:0]        chr_din;

   assign accept  = valid && ready;
   assign arg     = data - CH_SPACE;
   assign tab_col = {1'b0, cursor_col | TAB_MASK} + 1'b1;

   // ESC J/K start the engine on the accept cycle so the first erase lands one cycle later.
   always_comb begin
      fill_start = 1'b0;
      fill_from  = fill_lo;
      fill_to    = fill_hi;
      if (state == S_FILL_START) begin
         fill_start = 1'b1;
      end else if (accept && state == S_ESC && (data == ESC_EOS || data == ESC_EOL)) begin
         fill_start = 1'b1;
         fill_from  = {cursor_row, cursor_col};
         fill_to    = (data == ESC_EOL) ? {cursor_row, COL_MAX} : '1;
      end
   end

   fill_engine #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) u_fill (
      .clk       (clk),
      .clr       (clr),
      .start     (fill_start),
      .from      (fill_from),
      .to        (fill_to),
      .first_row (buffer_first_row),
      .busy      (fill_busy),
      .waddr     (fill_waddr),
      .wen       (fill_wen)
   );

   assign buffer_wen   = chr_wen | fill_wen;
   assign buffer_waddr = fill_wen ? fill_waddr : chr_addr;
   assign buffer_din   = fill_wen ? FILL_CHAR : chr_din;

   always_ff @(posedge clk) begin
      if (clr) begin
         state                <= S_INIT;
         ready                <= 1'b0;
         buffer_first_row     <= '0;
         buffer_first_row_wen <= 1'b0;
         cursor_row           <= '0;
         cursor_col           <= '0;
         chr_wen              <= 1'b0;
         chr_addr             <= '0;
         chr_din              <= '0;
         y_row                <= '0;
         fill_lo              <= '0;
         fill_hi              <= '0;
      end else begin
         buffer_first_row_wen <= 1'b0;
         chr_wen              <= 1'b0;
         case (state)
            S_INIT: begin
               buffer_first_row     <= '0;
               buffer_first_row_wen <= 1'b1;
               fill_lo              <= '0;
               fill_hi              <= '1;
               state                <= S_FILL_START;
            end
            S_FILL_START: state <= S_FILL;
            S_FILL: begin
               if (!fill_busy) begin
                  state <= S_IDLE;
                  ready <= 1'b1;
               end
            end
            S_IDLE: if (accept) begin
               if (data >= CH_SPACE && data < CH_DEL) begin
                  chr_wen  <= 1'b1;
                  chr_addr <= {buffer_first_row + cursor_row, cursor_col};
                  chr_din  <= data;
                  if (cursor_col != COL_MAX) cursor_col <= cursor_col + 1'b1;
               end else begin
                  case (data)
                     CH_CR:  cursor_col <= '0;
                     CH_LF: begin
                        if (cursor_row != ROW_MAX) begin
                           cursor_row <= cursor_row + 1'b1;
                        end else begin
                           // New bottom line is the old top line in the buffer.
                           buffer_first_row     <= buffer_first_row + 1'b1;
                           buffer_first_row_wen <= 1'b1;
                           fill_lo              <= {ROW_MAX, {COL_BITS{1'b0}}};
                           fill_hi              <= '1;
                           ready                <= 1'b0;
                           state                <= S_FILL_START;
                        end
                     end
                     CH_BS:  if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
                     CH_TAB: cursor_col <= tab_col[COL_BITS] ? COL_MAX : tab_col[COL_BITS-1:0];
                     CH_ESC: state <= S_ESC;
                     default: ;
                  endcase
               end
            end
            S_ESC: if (accept) begin
               state <= S_IDLE;
               case (data)
                  ESC_UP:    if (cursor_row != '0) cursor_row <= cursor_row - 1'b1;
                  ESC_DOWN:  if (cursor_row != ROW_MAX) cursor_row <= cursor_row + 1'b1;
                  ESC_RIGHT: if (cursor_col != COL_MAX) cursor_col <= cursor_col + 1'b1;
                  ESC_LEFT:  if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
                  ESC_HOME: begin
                     cursor_row <= '0;
                     cursor_col <= '0;
                  end
                  ESC_EOS, ESC_EOL: begin
                     ready <= 1'b0;
                     state <= S_FILL;
                  end
                  ESC_ADDR: state <= S_Y_ROW;
                  default: ;
               endcase
            end
            S_Y_ROW: if (accept) begin
               if (data < CH_SPACE)     y_row <= '0;
               else if (arg > ROW_LIM)  y_row <= ROW_MAX;
               else                     y_row <= arg[ROW_BITS-1:0];
               state <= S_Y_COL;
            end
            S_Y_COL: if (accept) begin
               cursor_row <= y_row;
               if (data < CH_SPACE)     cursor_col <= '0;
               else if (arg > COL_LIM)  cursor_col <= COL_MAX;
               else                     cursor_col <= arg[COL_BITS-1:0];
               state <= S_IDLE;
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_command_handler.sv
// Scoreboarded bench for command_handler: expected writes and scroll strobes are queued at stimulus time.
module tb_command_handler;
   localparam logic [7:0] ESC = 8'h1B;
   localparam logic [7:0] LF  = 8'h0A;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic [9:0] buffer_waddr;
   logic [7:0] buffer_din;
   logic       buffer_wen;
   logic [3:0] buffer_first_row;
   logic       buffer_first_row_wen;
   logic [3:0] cursor_row;
   logic [5:0] cursor_col;

   int checks = 0;
   int errors = 0;
   logic [17:0] exp_q[$];
   logic [3:0]  fr_q[$];
   logic [3:0]  m_fr = 4'd0;

   command_handler dut (
      .clk(clk), .clr(clr), .data(data), .valid(valid), .ready(ready),
      .buffer_waddr(buffer_waddr), .buffer_din(buffer_din), .buffer_wen(buffer_wen),
      .buffer_first_row(buffer_first_row), .buffer_first_row_wen(buffer_first_row_wen),
      .cursor_row(cursor_row), .cursor_col(cursor_col)
   );

   always #5 clk = ~clk;

   task automatic push_wr(input int r, input int c, input logic [7:0] ch);
      logic [3:0] pr;
      pr = m_fr + 4'(r);
      exp_q.push_back({pr, 6'(c), ch});
   endtask

   task automatic push_fill(input int from, input int to);
      for (int i = from; i <= to; i++) push_wr(i / 64, i % 64, 8'h20);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      data  = b;
      valid = 1'b1;
      while (!ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout byte=%h got ready=0 want 1", b);
         valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   task automatic count_low(output int low);
      low = 0;
      @(negedge clk);
      while (!ready && low < 3000) begin
         low++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int low;
      clr = 1'b1;
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({buffer_wen, buffer_first_row_wen, buffer_waddr, buffer_din, buffer_first_row, cursor_row, cursor_col} !== 34'd0) begin
         errors++;
         $display("FAIL reset_outputs got wen=%b frwen=%b addr=%h din=%h fr=%0d cur=(%0d,%0d) want all 0",
                  buffer_wen, buffer_first_row_wen, buffer_waddr, buffer_din, buffer_first_row, cursor_row, cursor_col);
      end
      m_fr = 4'd0;
      fr_q.push_back(4'd0);
      push_fill(0, 1023);
      clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (buffer_first_row_wen !== 1'b1 || buffer_wen !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL init_strobe got frwen=%b wen=%b ready=%b want 1 0 0", buffer_first_row_wen, buffer_wen, ready);
      end
      low = 1;
      @(negedge clk);
      while (!ready && low < 3000) begin
         low++;
         @(negedge clk);
      end
      checks++;
      if (low != 1025) begin errors++; $display("FAIL init_ready_low got %0d want 1025", low); end
      checks++;
      if (cursor_row !== 4'd0 || cursor_col !== 6'd0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL init_done got cur=(%0d,%0d) pending=%0d want (0,0) 0", cursor_row, cursor_col, exp_q.size());
      end
   endtask

   task automatic test_print();
      push_wr(0, 0, 8'h41);
      send(8'h41);
      @(negedge clk);
      checks++;
      if (buffer_wen !== 1'b1 || buffer_waddr !== 10'h000 || buffer_din !== 8'h41) begin
         errors++;
         $display("FAIL print_latency got wen=%b addr=%h din=%h want 1 000 41", buffer_wen, buffer_waddr, buffer_din);
      end
      push_wr(0, 1, 8'h42);
      send(8'h42);
      @(negedge clk);
      checks++;
      if (cursor_row !== 4'd0 || cursor_col !== 6'd2) begin
         errors++;
         $display("FAIL print_cursor got (%0d,%0d) want (0,2)", cursor_row, cursor_col);
      end
      for (int i = 0; i < 64; i++) begin
         push_wr(0, (2 + i > 63) ? 63 : 2 + i, 8'h78);
         send(8'h78);
      end
      @(negedge clk);
      checks++;
      if (cursor_col !== 6'd63 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL print_saturate got col=%0d pending=%0d want 63 0", cursor_col, exp_q.size());
      end
   endtask

   task automatic test_scroll();
      int low;
      send(ESC); send(8'h59); send(8'h2E); send(8'h25);
      send(LF);
      @(negedge clk);
      checks++;
      if (cursor_row !== 4'd15 || cursor_col !== 6'd5) begin
         errors++;
         $display("FAIL lf_cursor got (%0d,%0d) want (15,5)", cursor_row, cursor_col);
      end
      m_fr = 4'd1;
      fr_q.push_back(4'd1);
      push_fill(960, 1023);
      send(LF);
      count_low(low);
      checks++;
      if (low != 65) begin errors++; $display("FAIL scroll_ready_low got %0d want 65", low); end
      checks++;
      if (cursor_row !== 4'd15 || cursor_col !== 6'd5 || buffer_first_row !== 4'd1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL scroll_state got cur=(%0d,%0d) fr=%0d pending=%0d want (15,5) 1 0",
                  cursor_row, cursor_col, buffer_first_row, exp_q.size());
      end
      push_wr(15, 5, 8'h51);
      send(8'h51);
      @(negedge clk);
      checks++;
      if (buffer_wen !== 1'b1 || buffer_waddr !== 10'h005) begin
         errors++;
         $display("FAIL scroll_print got wen=%b addr=%h want 1 005", buffer_wen, buffer_waddr);
      end
   endtask

   task automatic test_erase();
      int low;
      send(ESC); send(8'h59); send(8'h23); send(8'h2A);
      push_fill(3 * 64 + 10, 3 * 64 + 63);
      send(ESC); send(8'h4B);
      count_low(low);
      checks++;
      if (low != 54) begin errors++; $display("FAIL eol_ready_low got %0d want 54", low); end
      checks++;
      if (cursor_row !== 4'd3 || cursor_col !== 6'd10 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL eol_state got cur=(%0d,%0d) pending=%0d want (3,10) 0", cursor_row, cursor_col, exp_q.size());
      end
      send(ESC); send(8'h59); send(8'h2E); send(8'h5C);
      push_fill(14 * 64 + 60, 1023);
      send(ESC); send(8'h4A);
      count_low(low);
      checks++;
      if (low != 68) begin errors++; $display("FAIL eos_ready_low got %0d want 68", low); end
      checks++;
      if (cursor_row !== 4'd14 || cursor_col !== 6'd60 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL eos_state got cur=(%0d,%0d) pending=%0d want (14,60) 0", cursor_row, cursor_col, exp_q.size());
      end
   endtask

   task automatic test_edges();
      send(ESC); send(8'h59); send(8'h20); send(8'h20);
      send(8'h08);
      @(negedge clk);
      checks++;
      if (cursor_row !== 4'd0 || cursor_col !== 6'd0) begin
         errors++; $display("FAIL bs_saturate got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
      end
      send(8'h09);
      @(negedge clk);
      checks++;
      if (cursor_col !== 6'd8) begin errors++; $display("FAIL tab_from_0 got %0d want 8", cursor_col); end
      send(ESC); send(8'h59); send(8'h20); send(8'h5C);
      send(8'h09);
      @(negedge clk);
      checks++;
      if (cursor_col !== 6'd63) begin errors++; $display("FAIL tab_from_60 got %0d want 63", cursor_col); end
      send(ESC); send(8'h41);
      @(negedge clk);
      checks++;
      if (cursor_row !== 4'd0 || cursor_col !== 6'd63) begin
         errors++; $display("FAIL esc_up_saturate got (%0d,%0d) want (0,63)", cursor_row, cursor_col);
      end
      send(ESC); send(8'h5A);
      push_wr(0, 63, 8'h61);
      send(8'h61);
      @(negedge clk);
      checks++;
      if (buffer_wen !== 1'b1 || buffer_waddr !== 10'h07F || buffer_din !== 8'h61) begin
         errors++;
         $display("FAIL esc_unknown_then_print got wen=%b addr=%h din=%h want 1 07f 61", buffer_wen, buffer_waddr, buffer_din);
      end
      send(ESC); send(ESC);
      push_wr(0, 63, 8'h62);
      send(8'h62);
      send(8'h01);
      send(ESC); send(8'h59); send(8'h7F); send(8'h10);
      @(negedge clk);
      checks++;
      if (cursor_row !== 4'd15 || cursor_col !== 6'd0) begin
         errors++; $display("FAIL y_clamp got (%0d,%0d) want (15,0)", cursor_row, cursor_col);
      end
      send(ESC); send(8'h42);
      send(ESC); send(8'h43);
      send(ESC); send(8'h44); send(ESC); send(8'h44);
      @(negedge clk);
      checks++;
      if (cursor_row !== 4'd15 || cursor_col !== 6'd0 || buffer_first_row !== 4'd1 || exp_q.size() != 0 || fr_q.size() != 0) begin
         errors++;
         $display("FAIL cursor_moves got cur=(%0d,%0d) fr=%0d pending=%0d want (15,0) 1 0",
                  cursor_row, cursor_col, buffer_first_row, exp_q.size());
      end
   endtask

   task automatic test_clr_mid_fill();
      int low;
      send(ESC); send(8'h48);
      push_fill(0, 1023);
      send(ESC); send(8'h4A);
      repeat (100) @(negedge clk);
      @(posedge clk);
      #1 clr = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 clr = 1'b0;
      m_fr = 4'd0;
      fr_q.push_back(4'd0);
      push_fill(0, 1023);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (buffer_first_row_wen !== 1'b1 || buffer_first_row !== 4'd0) begin
         errors++;
         $display("FAIL clr_restart got frwen=%b fr=%0d want 1 0", buffer_first_row_wen, buffer_first_row);
      end
      low = 1;
      @(negedge clk);
      while (!ready && low < 3000) begin
         low++;
         @(negedge clk);
      end
      checks++;
      if (low != 1025 || cursor_row !== 4'd0 || cursor_col !== 6'd0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL clr_reclear got low=%0d cur=(%0d,%0d) pending=%0d want 1025 (0,0) 0",
                  low, cursor_row, cursor_col, exp_q.size());
      end
   endtask

   initial begin
      fork
         begin : monitor
            logic [17:0] e;
            logic [3:0]  f;
            forever begin
               @(negedge clk);
               if (!clr) begin
                  if (buffer_wen && buffer_first_row_wen) begin
                     checks++;
                     errors++;
                     $display("FAIL strobe_overlap got both strobes high want at most one");
                  end
                  if (buffer_wen) begin
                     checks++;
                     if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected got addr=%h din=%h want no write", buffer_waddr, buffer_din);
                     end else begin
                        e = exp_q.pop_front();
                        if ({buffer_waddr, buffer_din} !== e) begin
                           errors++;
                           $display("FAIL write_data got addr=%h din=%h want addr=%h din=%h",
                                    buffer_waddr, buffer_din, e[17:8], e[7:0]);
                        end
                     end
                  end
                  if (buffer_first_row_wen) begin
                     checks++;
                     if (fr_q.size() == 0) begin
                        errors++;
                        $display("FAIL first_row_unexpected got val=%0d want no strobe", buffer_first_row);
                     end else begin
                        f = fr_q.pop_front();
                        if (buffer_first_row !== f) begin
                           errors++;
                           $display("FAIL first_row_val got %0d want %0d", buffer_first_row, f);
                        end
                     end
                  end
               end
            end
         end
      join_none

      test_reset();
      test_print();
      test_scroll();
      test_erase();
      test_edges();
      test_clr_mid_fill();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
